std_skid_ctrl: RTL and testbench
================================

Name: std_skid_ctrl

Overview:
- Two-entry skid-buffer controller for one valid/ready pipeline stage.
- Sequences two internal enable-DFF registers, main and skid, by generating their load enables and muxing their data. This breaks the combinational ready path between stages at full throughput.
- Standard building block placed between Taurus 3001 pipeline stages and on bus-interface boundaries.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DATA_RESET_VALUE, 'b0, reset value of the main and skid data registers.

Ports:
- clk  input  1  clock, all state on rising edge.
- aresetn  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous flush; discards all buffered entries.
- s_valid  input  1  upstream payload valid.
- s_ready  output  1  upstream ready (registered).
- s_data  input  DATA_WIDTH  upstream payload.
- m_valid  output  1  downstream payload valid (registered).
- m_ready  input  1  downstream ready.
- m_data  output  DATA_WIDTH  downstream payload (driven directly from the main register).
- occupancy  output  2  number of buffered entries, 0..2.

Behaviour:
- Reset: clk is the clock; aresetn is the reset, asynchronous, active-low. While aresetn=0 the block holds these values:
  - state=EMPTY, m_valid=0, s_ready=1, occupancy=0.
  - main and skid data registers = DATA_RESET_VALUE, so m_data = DATA_RESET_VALUE.
- Handshake events:
  - s_fire = s_valid & s_ready.
  - m_fire = m_valid & m_ready.
  - Transfers occur on the rising clk edge when the corresponding fire is 1.
- States:
  - EMPTY: occupancy 0.
  - BUSY: occupancy 1, main register valid.
  - FULL: occupancy 2, main and skid registers valid.
- Registered outputs are derived from state only:
  - m_valid = (state != EMPTY).
  - s_ready = (state != FULL).
  - There is no combinational path from m_ready to s_ready, or from s_valid to m_valid.
- Transitions (flush = 0):
  - EMPTY, s_fire: main <= s_data, go to BUSY.
  - EMPTY, no s_fire: stay in EMPTY.
  - BUSY, s_fire & m_fire: main <= s_data, stay in BUSY.
  - BUSY, s_fire & ~m_fire: skid <= s_data, go to FULL.
  - BUSY, ~s_fire & m_fire: go to EMPTY.
  - BUSY, neither: hold.
  - FULL, m_fire: main <= skid, go to BUSY. s_fire is impossible in FULL because s_ready = 0.
  - FULL, ~m_fire: hold.
- Register enables:
  - Main register enable is asserted only on the load cases above. Skid register enable is asserted only on the BUSY -> FULL transition.
  - Registers not enabled hold their value. m_data stays stable while m_valid & ~m_ready.
- Flush:
  - flush = 1 forces next state = EMPTY, regardless of s_fire or m_fire.
  - An s_fire in the flush cycle is accepted on the wire and its data discarded.
  - An m_fire in the flush cycle completes normally, because downstream already sampled the data.
  - Data registers are not cleared by flush; only validity is cleared.
- Latency and throughput:
  - Latency is 1 cycle from s_fire to m_valid when EMPTY.
  - Sustained throughput is 1 transfer per cycle with m_ready held at 1.
  - Ordering is strictly FIFO: main is always older than skid.
- Invariants checked by the bench:
  - occupancy equals the number of valid entries.
  - Never m_valid = 0 while the skid entry is valid.
  - Never s_ready = 0 while m_valid = 0.
- Reset mid-operation: asynchronous return to the reset values above; buffered data is lost.

Test Plan:
- Reset, then hold s_valid=0, m_ready=1 for 3 cycles -> m_valid=0, s_ready=1, occupancy=0, m_data=DATA_RESET_VALUE throughout.
- Streaming: s_valid=1 with s_data=1,2,3,4 on consecutive cycles, m_ready=1 -> m_data=1,2,3,4 on cycles 1-4 after the first s_fire; s_ready stays 1; occupancy stays 1.
- Backpressure:
  - Push 0xA then 0xB with m_ready=0 -> occupancy=2 and s_ready=0 after the second edge; m_data holds 0xA.
  - s_valid with 0xC while FULL is not accepted.
  - Raise m_ready -> m_data=0xA, 0xB, then 0xC, with no loss or duplication.
- Simultaneous push and pop in BUSY (main=0x5, s_data=0x6, both fires) -> next cycle m_data=0x6, occupancy=1, skid enable never asserted.
- Flush in FULL with s_valid=1, s_data=0x7 -> next cycle m_valid=0, s_ready=1, occupancy=0. A following push of 0x8 appears as m_data=0x8; 0x7 never appears.
- Assert aresetn=0 asynchronously mid-cycle while FULL -> m_valid=0 and s_ready=1 immediately, without waiting for a clk edge; m_data=DATA_RESET_VALUE.

Source files
------------

// File: rtl/std_skid_ctrl.sv
// std_skid_ctrl: two-entry skid buffer for one valid/ready pipeline stage.
// The main and skid data registers are plain enable flops; this block
// generates their load enables and the main-register input mux. Both
// handshake outputs come straight from the state register, so m_ready never
// reaches s_ready combinationally and s_valid never reaches m_valid.
module std_skid_ctrl #(
    parameter int                    DATA_WIDTH       = 32,
    parameter logic [DATA_WIDTH-1:0] DATA_RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occupancy
);

    // State encoding equals the number of buffered entries.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] BUSY  = 2'b01;
    localparam logic [1:0] FULL  = 2'b10;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [DATA_WIDTH-1:0] main_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [DATA_WIDTH-1:0] main_next;
    logic                  main_en;
    logic                  skid_en;
    logic                  s_fire;
    logic                  m_fire;

    assign m_valid   = (state != EMPTY);
    assign s_ready   = (state != FULL);
    assign s_fire    = s_valid & s_ready;
    assign m_fire    = m_valid & m_ready;
    assign m_data    = main_data;
    assign occupancy = (state == FULL) ? 2'd2 : ((state == BUSY) ? 2'd1 : 2'd0);

    // Next state, register enables and main-register source selection.
    always_comb begin
        state_next = state;
        main_en    = 1'b0;
        skid_en    = 1'b0;
        main_next  = s_data;
        case (state)
            EMPTY: begin
                if (s_fire) begin
                    main_en    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (s_fire && m_fire) begin
                    main_en = 1'b1;
                end else if (s_fire) begin
                    skid_en    = 1'b1;
                    state_next = FULL;
                end else if (m_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (m_fire) begin
                    main_en    = 1'b1;
                    main_next  = skid_data;
                    state_next = BUSY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        // Flush drops validity only; loads are suppressed so a discarded
        // payload never lands in the data registers.
        if (flush) begin
            state_next = EMPTY;
            main_en    = 1'b0;
            skid_en    = 1'b0;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Main and skid data registers; each holds unless its enable is set.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            main_data <= DATA_RESET_VALUE;
            skid_data <= DATA_RESET_VALUE;
        end else begin
            if (main_en) begin
                main_data <= main_next;
            end
            if (skid_en) begin
                skid_data <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_std_skid_ctrl.sv
// Testbench for std_skid_ctrl: directed scenarios followed by random traffic.
// A queue models the buffer contents; a negedge monitor compares the DUT
// against it and pops the queue on every downstream transfer.
module tb_std_skid_ctrl;

    localparam int                DW      = 32;
    localparam logic [DW-1:0]     RST_VAL = 32'h5A5A_0001;

    logic          clk;
    logic          aresetn;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    occupancy;

    int compare_count = 0;
    int fail_count    = 0;
    logic [DW-1:0] model_q[$];

    std_skid_ctrl #(
        .DATA_WIDTH      (DW),
        .DATA_RESET_VALUE(RST_VAL)
    ) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .flush    (flush),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .occupancy(occupancy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison with failure report.
    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        compare_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, settle just after it.
    task automatic applyStimulus(input logic sv, input logic [DW-1:0] sd,
                                 input logic mr, input logic fl);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard: mid-cycle, compare outputs with the modelled
    // buffer, then apply the transfers the coming edge will perform.
    always @(negedge clk) begin
        int  depth;
        bit  sf;
        bit  mf;
        logic [DW-1:0] front;
        if (!aresetn) begin
            model_q.delete();
            checkOutput("reset m_valid", {31'b0, m_valid}, 32'd0);
            checkOutput("reset s_ready", {31'b0, s_ready}, 32'd1);
            checkOutput("reset occupancy", {30'b0, occupancy}, 32'd0);
            checkOutput("reset m_data", m_data, RST_VAL);
        end else begin
            depth = model_q.size();
            checkOutput("m_valid", {31'b0, m_valid}, {31'b0, depth != 0});
            checkOutput("s_ready", {31'b0, s_ready}, {31'b0, depth < 2});
            checkOutput("occupancy", {30'b0, occupancy}, depth);
            if (depth != 0) begin
                checkOutput("m_data", m_data, model_q[0]);
            end
            sf = s_valid && (depth < 2);
            mf = m_ready && (depth != 0);
            if (mf) begin
                front = model_q.pop_front();
                checkOutput("scoreboard pop", m_data, front);
            end
            if (flush) begin
                model_q.delete();
            end else if (sf) begin
                model_q.push_back(s_data);
            end
        end
    end

    // Watchdog: the run is a fixed number of cycles, this only catches a stall.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then random traffic, then summary.
    initial begin
        aresetn = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("idle m_valid", {31'b0, m_valid}, 32'd0);
            checkOutput("idle m_data", m_data, RST_VAL);
        end

        // Streaming at full rate.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, k, 1'b1, 1'b0);
            checkOutput("stream m_data", m_data, k);
            checkOutput("stream occupancy", {30'b0, occupancy}, 32'd1);
            checkOutput("stream s_ready", {31'b0, s_ready}, 32'd1);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Backpressure fills both entries; third payload is refused.
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
        checkOutput("bp occupancy", {30'b0, occupancy}, 32'd2);
        checkOutput("bp s_ready", {31'b0, s_ready}, 32'd0);
        checkOutput("bp m_data", m_data, 32'hA);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
        checkOutput("bp hold m_data", m_data, 32'hA);
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
        checkOutput("bp drain B", m_data, 32'hB);
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
        checkOutput("bp drain C", m_data, 32'hC);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("bp empty", {31'b0, m_valid}, 32'd0);

        // Simultaneous push and pop in BUSY.
        applyStimulus(1'b1, 32'h5, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h6, 1'b1, 1'b0);
        checkOutput("pushpop m_data", m_data, 32'h6);
        checkOutput("pushpop occupancy", {30'b0, occupancy}, 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Flush while FULL, then a fresh push.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h7, 1'b0, 1'b1);
        checkOutput("flush m_valid", {31'b0, m_valid}, 32'd0);
        checkOutput("flush s_ready", {31'b0, s_ready}, 32'd1);
        checkOutput("flush occupancy", {30'b0, occupancy}, 32'd0);
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
        checkOutput("post-flush m_data", m_data, 32'h8);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Flush in BUSY with an accepted push that must be discarded.
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h21, 1'b0, 1'b1);
        checkOutput("flush busy occupancy", {30'b0, occupancy}, 32'd0);

        // Asynchronous reset mid-cycle while FULL.
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h31, 1'b0, 1'b0);
        s_valid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("async m_valid", {31'b0, m_valid}, 32'd0);
        checkOutput("async s_ready", {31'b0, s_ready}, 32'd1);
        checkOutput("async m_data", m_data, RST_VAL);
        @(posedge clk);
        #1;
        aresetn = 1'b1;

        // Random traffic with occasional flushes.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                          ($urandom % 25) == 0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("final drained", {31'b0, m_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
